// File: rtl/kpyd_scan_decoder_if.sv
// Key-event channel from the keypad scan decoder to its consumer.
// Latency: none, this is wiring only. Backpressure: the consumer holds ready_i low to stall.
// Signals: code_o (key code), valid_o (event present), ready_i (consumer accepts),
//          overrun_o (a debounced press was dropped because the entry was still full).
interface kpyd_scan_decoder_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic              ready_i;
  logic              overrun_o;

  modport master (output code_o, output valid_o, output overrun_o, input ready_i);
  modport slave  (input code_o, input valid_o, input overrun_o, output ready_i);
endinterface

// File: rtl/kpyd_scan_decoder.sv
// Matrix-keypad scanner: one-hot column strobes, 2-flop row synchroniser, scan debounce, key-code events.
// Latency: valid_o rises one clock after the EVAL cycle that accepts a press.
// Backpressure: single-entry output; a press accepted while the entry is full and ready_i=0 is
//               dropped and flagged with a one-cycle overrun_o pulse.
// Ports: clk_i, reset_i (async, active-high), row_i (raw rows), col_o (column strobes),
//        evt (master side of the key-event channel).
module kpyd_scan_decoder #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CODE_W         = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_COLS-1:0] col_o,
  kpyd_scan_decoder_if.master evt
);

  localparam int NKEYS = NUM_ROWS * NUM_COLS;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int CYC_W = $clog2(SCAN_CYCLES);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SCAN_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0] DEB      = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic {SCAN, EVAL} state_t;

  state_t              state;
  logic [COL_W-1:0]    col_idx;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [NUM_ROWS-1:0] row_s1;
  logic [NUM_ROWS-1:0] row_s2;
  logic [NKEYS-1:0]    image;

  // Debounce candidate: MULTI is folded into NONE, so only "single key k" or "no key" exist.
  logic                cand_single;
  logic [CODE_W-1:0]   cand_key;
  logic [CNT_W-1:0]    stable_cnt;
  logic                held;

  logic [CODE_W-1:0]   code_q;
  logic                valid_q;
  logic                overrun_q;

  // Scan-image classification
  logic [1:0]          hits;
  logic [CODE_W-1:0]   hit_key;
  logic                cls_single;
  logic [CODE_W-1:0]   cls_key;
  logic                same_cls;
  logic [CNT_W-1:0]    nxt_cnt;
  logic                press_acc;
  logic                rel_acc;

  always_comb begin
    hits    = 2'd0;
    hit_key = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (image[c*NUM_ROWS + r]) begin
          if (hits != 2'd2) hits = hits + 2'd1;
          hit_key = CODE_W'(r * NUM_COLS + c);
        end
      end
    end
    cls_single = (hits == 2'd1);
    // Zero the key when not single so "no key" always compares equal to itself.
    cls_key    = cls_single ? hit_key : '0;
    same_cls   = (cls_single == cand_single) && (cls_key == cand_key);
    if (!same_cls)             nxt_cnt = CNT_W'(1);
    else if (stable_cnt == DEB) nxt_cnt = DEB;
    else                       nxt_cnt = stable_cnt + CNT_W'(1);
    press_acc = (state == EVAL) && (nxt_cnt == DEB) &&  cls_single && !held;
    rel_acc   = (state == EVAL) && (nxt_cnt == DEB) && !cls_single;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= SCAN;
      col_idx     <= '0;
      cyc_cnt     <= '0;
      col_o       <= NUM_COLS'(1);
      row_s1      <= '0;
      row_s2      <= '0;
      image       <= '0;
      cand_single <= 1'b0;
      cand_key    <= '0;
      stable_cnt  <= '0;
      held        <= 1'b0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      row_s1    <= row_i;
      row_s2    <= row_s1;
      overrun_q <= 1'b0;

      case (state)
        SCAN: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            // Sample only at column end, after the synchroniser has settled on this column.
            for (int c = 0; c < NUM_COLS; c++) begin
              if (col_idx == COL_W'(c)) image[c*NUM_ROWS +: NUM_ROWS] <= row_s2;
            end
            if (col_idx == COL_LAST) begin
              state <= EVAL;
              col_o <= '0;
            end else begin
              col_idx <= col_idx + COL_W'(1);
              col_o   <= NUM_COLS'(1) << (col_idx + COL_W'(1));
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end

        EVAL: begin
          state       <= SCAN;
          col_idx     <= '0;
          col_o       <= NUM_COLS'(1);
          cand_single <= cls_single;
          cand_key    <= cls_key;
          stable_cnt  <= nxt_cnt;
          if (press_acc) held <= 1'b1;
          else if (rel_acc) held <= 1'b0;
        end

        default: state <= SCAN;
      endcase

      // Single-entry output; a simultaneous drain and load refills with no bubble.
      if (press_acc && (!valid_q || evt.ready_i)) begin
        code_q  <= cls_key;
        valid_q <= 1'b1;
      end else begin
        if (press_acc) overrun_q <= 1'b1;
        if (valid_q && evt.ready_i) valid_q <= 1'b0;
      end
    end
  end

  assign evt.code_o    = code_q;
  assign evt.valid_o   = valid_q;
  assign evt.overrun_o = overrun_q;

endmodule

// File: tb/tb_kpyd_scan_decoder.sv
// Directed bench for kpyd_scan_decoder at default parameters (4x4, 4 clocks/column, 3-scan debounce).
// A behavioural keypad turns the pressed-key vector plus col_o into row_i; key changes happen only
// in EVAL cycles so each scan sees one clean pattern.
module tb_kpyd_scan_decoder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int ovr_cnt = 0;
  int base;
  logic [3:0] last_code = 4'd0;

  kpyd_scan_decoder_if #(.CODE_W(4)) evt_if ();

  kpyd_scan_decoder dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .row_i   (row_i),
    .col_o   (col_o),
    .evt     (evt_if)
  );

  always #5 clk_i = ~clk_i;

  // Keypad model: key (r,c) shorts column c to row r.
  always_comb begin
    row_i = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && col_o[c]) row_i[r] = 1'b1;
  end

  // Transfer / overrun monitors.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (evt_if.valid_o && evt_if.ready_i) begin
        xfer_cnt  = xfer_cnt + 1;
        last_code = evt_if.code_o;
      end
      if (evt_if.overrun_o) ovr_cnt = ovr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Advance to the negedge of the next EVAL cycle (col_o == 0), bounded.
  task automatic sync_eval();
    int n;
    n = 0;
    while (col_o !== 4'd0 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("eval_reached", {31'd0, col_o === 4'd0}, 32'd1);
  endtask

  task automatic run_scans(input int n);
    repeat (n) begin
      tick(1);
      sync_eval();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    keys = 16'h0000;
    evt_if.ready_i = 1'b1;
    tick(2);
    chk("rst_col", col_o, 4'b0001);
    chk("rst_valid", evt_if.valid_o, 1'b0);
    chk("rst_code", evt_if.code_o, 4'd0);
    chk("rst_overrun", evt_if.overrun_o, 1'b0);
    reset_i = 1'b0;
    chk("col0_after_rst", col_o, 4'b0001);
    tick(4);
    chk("col1_strobe", col_o, 4'b0010);
    sync_eval();

    // Scan period: col0 for ticks 1..4, col3 for 13..16, EVAL at 17.
    tick(1);
    chk("period_col0", col_o, 4'b0001);
    tick(15);
    chk("period_col3", col_o, 4'b1000);
    tick(1);
    chk("period_eval", col_o, 4'b0000);

    // Press r1c2 -> code 6 after 3 scans.
    keys = 16'h0040;
    run_scans(2);
    chk("p6_scan2_valid", evt_if.valid_o, 1'b0);
    run_scans(1);
    chk("p6_eval3_valid", evt_if.valid_o, 1'b0);
    tick(1);
    chk("p6_valid", evt_if.valid_o, 1'b1);
    chk("p6_code", evt_if.code_o, 4'd6);
    tick(1);
    chk("p6_drained", evt_if.valid_o, 1'b0);
    chk("p6_xfer", xfer_cnt, 32'd1);
    sync_eval();
    run_scans(4);
    chk("p6_no_repeat", xfer_cnt, 32'd1);
    keys = 16'h0000;
    run_scans(3);

    // Hold r3c3 for 20 scans, release 3, re-press.
    base = xfer_cnt;
    keys = 16'h8000;
    run_scans(20);
    chk("p15_hold_xfer", xfer_cnt, base + 1);
    chk("p15_code", last_code, 4'd15);
    keys = 16'h0000;
    run_scans(3);
    keys = 16'h8000;
    run_scans(3);
    tick(2);
    chk("p15_repress_xfer", xfer_cnt, base + 2);
    chk("p15_repress_code", last_code, 4'd15);
    sync_eval();
    keys = 16'h0000;
    run_scans(3);

    // Bounce r0c1 on/off for 5 scans (ending on), then steady.
    base = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'h0002 : 16'h0000;
      run_scans(1);
    end
    chk("bounce_no_event", xfer_cnt, base);
    keys = 16'h0002;
    run_scans(1);
    chk("bounce_steady2", evt_if.valid_o, 1'b0);
    run_scans(1);
    chk("bounce_steady3_eval", evt_if.valid_o, 1'b0);
    tick(1);
    chk("bounce_valid", evt_if.valid_o, 1'b1);
    chk("bounce_code", evt_if.code_o, 4'd1);
    tick(1);
    chk("bounce_xfer", xfer_cnt, base + 1);
    sync_eval();
    keys = 16'h0000;
    run_scans(3);

    // Ghosting guard: r0c0 + r2c1 together, then drop r2c1.
    base = xfer_cnt;
    keys = 16'h0201;
    run_scans(10);
    chk("multi_no_event", xfer_cnt, base);
    chk("multi_valid", evt_if.valid_o, 1'b0);
    keys = 16'h0001;
    run_scans(2);
    chk("multi_rel_scan2", evt_if.valid_o, 1'b0);
    run_scans(1);
    tick(1);
    chk("multi_rel_valid", evt_if.valid_o, 1'b1);
    chk("multi_rel_code", evt_if.code_o, 4'd0);
    tick(1);
    chk("multi_rel_xfer", xfer_cnt, base + 1);
    sync_eval();
    keys = 16'h0000;
    run_scans(3);

    // Overrun: ready low, press 5, release, press 9.
    base = xfer_cnt;
    evt_if.ready_i = 1'b0;
    keys = 16'h0020;
    run_scans(3);
    tick(1);
    chk("ovr_valid5", evt_if.valid_o, 1'b1);
    chk("ovr_code5", evt_if.code_o, 4'd5);
    sync_eval();
    keys = 16'h0000;
    run_scans(3);
    keys = 16'h0200;
    run_scans(3);
    chk("ovr_pre_pulse", evt_if.overrun_o, 1'b0);
    tick(1);
    chk("ovr_pulse", evt_if.overrun_o, 1'b1);
    chk("ovr_valid_held", evt_if.valid_o, 1'b1);
    chk("ovr_code_held", evt_if.code_o, 4'd5);
    tick(1);
    chk("ovr_pulse_end", evt_if.overrun_o, 1'b0);
    chk("ovr_count", ovr_cnt, 32'd1);
    evt_if.ready_i = 1'b1;
    tick(1);
    chk("ovr_drained", evt_if.valid_o, 1'b0);
    chk("ovr_xfer", xfer_cnt, base + 1);
    chk("ovr_xfer_code", last_code, 4'd5);
    sync_eval();
    keys = 16'h0000;
    run_scans(4);
    chk("ovr_no_9", xfer_cnt, base + 1);

    // Reset mid-column with r2c2 held and an event pending.
    evt_if.ready_i = 1'b0;
    keys = 16'h0400;
    run_scans(3);
    tick(1);
    chk("rst2_pre_valid", evt_if.valid_o, 1'b1);
    chk("rst2_pre_code", evt_if.code_o, 4'd10);
    tick(5);
    reset_i = 1'b1;
    #1;
    chk("rst2_col", col_o, 4'b0001);
    chk("rst2_valid", evt_if.valid_o, 1'b0);
    chk("rst2_code", evt_if.code_o, 4'd0);
    tick(2);
    reset_i = 1'b0;
    base = xfer_cnt;
    sync_eval();
    run_scans(1);
    tick(1);
    chk("rst2_scan2_valid", evt_if.valid_o, 1'b0);
    sync_eval();
    chk("rst2_scan3_eval", evt_if.valid_o, 1'b0);
    tick(1);
    chk("rst2_valid10", evt_if.valid_o, 1'b1);
    chk("rst2_code10", evt_if.code_o, 4'd10);
    evt_if.ready_i = 1'b1;
    tick(1);
    chk("rst2_drained", evt_if.valid_o, 1'b0);
    chk("rst2_xfer", xfer_cnt, base + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
